// File: rtl/sram_responder.sv
// Single-port 24-bit RGB SRAM responder with fixed read latency, a busy window
// while a read is in flight, a sticky error flag and saturating op counters.
module sram_responder #(
    parameter int DEPTH_BITS   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [23:0] w_data,
    output logic [23:0] r_data,
    output logic        r_valid,
    output logic        busy,
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;

    logic [23:0] mem [0:(1<<DEPTH_BITS)-1];
    logic [1:0]  state;
    logic [1:0]  wait_cnt;
    logic [23:0] snap;
    logic        accept, rd_acc, wr_acc, both, in_range;
    logic [23:0] rd_word;

    assign in_range = (32'(address) >> DEPTH_BITS) == 32'd0;
    assign accept   = (state == IDLE) || (state == RD_DATA);
    assign rd_acc   = accept && read_enable && !write_enable;
    assign wr_acc   = accept && write_enable && !read_enable;
    assign both     = accept && read_enable && write_enable;
    // Out-of-range reads complete normally but return zero.
    assign rd_word  = in_range ? mem[address[DEPTH_BITS-1:0]] : 24'h000000;

    assign r_valid = (state == RD_DATA);
    assign busy    = (state == RD_WAIT);

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc && in_range)
            mem[address[DEPTH_BITS-1:0]] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
            snap     <= 24'h000000;
            r_data   <= 24'h000000;
            err      <= 1'b0;
            rd_count <= 16'h0000;
            wr_count <= 16'h0000;
        end else begin
            if (both || ((rd_acc || wr_acc) && !in_range))
                err <= 1'b1;
            if (wr_acc && in_range && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (rd_acc && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;

            case (state)
                RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state  <= RD_DATA;
                        r_data <= snap;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                default: begin
                    if (rd_acc) begin
                        if (READ_LATENCY == 1) begin
                            state  <= RD_DATA;
                            r_data <= rd_word;
                        end else begin
                            state    <= RD_WAIT;
                            wait_cnt <= 2'(READ_LATENCY - 2);
                            snap     <= rd_word;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
